gap_sync_ctrl: RTL and testbench

GAP_SYNC_CTRL -- requirements
Module: gap_sync_ctrl

---
 rtl/hwag_pkg.sv | 22 ++
 rtl/period_capture.sv | 38 +++
 rtl/gap_sync_ctrl.sv | 125 ++++++++++++
 tb/tb_gap_sync_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared definitions for the hardware angle-generator blocks: crank sync states,
// 60-2 wheel defaults and the error-counter width.
package hwag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEARCH,
    ST_SYNC
  } sync_state_t;

  localparam int TOOTH_NUM_DEF = 58;
  localparam int TOOTH_W       = 6;
  localparam int ERR_CNT_W     = 8;

  // Tooth index that follows tn on a wheel with `teeth` physical teeth.
  function automatic logic [TOOTH_W-1:0] next_tooth(input logic [TOOTH_W-1:0] tn,
                                                    input int teeth);
    return (tn == TOOTH_W'(teeth - 1)) ? '0 : tn + TOOTH_W'(1);
  endfunction

endpackage

// File: rtl/period_capture.sv
// Tooth period measurement: free-running clock count since the last strobe and
// a three-deep history of captured periods.
module period_capture #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_strobe,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cap0,
  output logic [WIDTH-1:0] cap1,
  output logic [WIDTH-1:0] cap2,
  output logic             cap_vld
);

  // NOTE: non-blocking assignments make cap2<=cap1<=cap0<=cnt all read the
  // pre-edge values, so the history shifts by exactly one slot per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      cap0    <= '0;
      cap1    <= '0;
      cap2    <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= cap_strobe;
      if (cap_strobe) begin
        cap2 <= cap1;
        cap1 <= cap0;
        cap0 <= cnt;
        cnt  <= WIDTH'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/gap_sync_ctrl.sv
// Crank-wheel gap synchroniser for a missing-tooth wheel. Define
// GAP_SYNC_ERR_CNT_EN to enable the saturating sync-loss counter on err_cnt.
module gap_sync_ctrl
  import hwag_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int TOOTH_NUM = TOOTH_NUM_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_strobe,
  input  logic [WIDTH-1:0]     min,
  input  logic [WIDTH-1:0]     max,
  input  logic                 err_clr,
  output logic [TOOTH_W-1:0]   tooth_num,
  output logic                 sync,
  output logic                 gap_pulse,
  output logic                 err_pulse,
  output logic                 stall,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0]   cnt, cap0, cap1, cap2, half1;
  logic               cap_vld, gap, noise, timeout;
  logic [TOOTH_W-1:0] nxt_tooth;
  logic [1:0]         fill_cnt;
  sync_state_t        state;

  period_capture #(.WIDTH(WIDTH)) u_capture (
    .clk        (clk),
    .rst        (rst),
    .cap_strobe (cap_strobe),
    .cnt        (cnt),
    .cap0       (cap0),
    .cap1       (cap1),
    .cap2       (cap2),
    .cap_vld    (cap_vld)
  );

  // A gap is a period more than twice as long as both of its neighbours.
  assign half1     = cap1 >> 1;
  assign gap       = (cap0 < half1) && (cap2 < half1);
  assign noise     = (cap0 <= min);
  assign timeout   = (state != ST_IDLE) && (cnt == max) && !cap_strobe;
  assign nxt_tooth = next_tooth(tooth_num, TOOTH_NUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      tooth_num <= '0;
      sync      <= 1'b0;
      gap_pulse <= 1'b0;
      err_pulse <= 1'b0;
      stall     <= 1'b0;
    end else begin
      gap_pulse <= 1'b0;
      err_pulse <= 1'b0;
      if (cap_strobe) stall <= 1'b0;

      if (cap_vld) begin
        case (state)
          ST_IDLE: begin
            state    <= ST_FILL;
            fill_cnt <= '0;
          end
          ST_FILL: begin
            if (noise) begin
              fill_cnt <= '0;
            end else if (fill_cnt == 2'd2) begin
              state    <= ST_SEARCH;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 2'd1;
            end
          end
          ST_SEARCH: begin
            if (gap && !noise) begin
              state     <= ST_SYNC;
              tooth_num <= TOOTH_W'(1);
              sync      <= 1'b1;
              gap_pulse <= 1'b1;
            end
          end
          ST_SYNC: begin
            // Gap must appear exactly on the 0->1 step and nowhere else.
            if (noise || (gap != (nxt_tooth == TOOTH_W'(1)))) begin
              state     <= ST_FILL;
              fill_cnt  <= '0;
              tooth_num <= '0;
              sync      <= 1'b0;
              err_pulse <= 1'b1;
            end else begin
              tooth_num <= nxt_tooth;
              gap_pulse <= (nxt_tooth == TOOTH_W'(1));
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout) begin
        state     <= ST_IDLE;
        stall     <= 1'b1;
        sync      <= 1'b0;
        tooth_num <= '0;
      end
    end
  end

`ifdef GAP_SYNC_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_pulse && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gap_sync_ctrl.sv
// Directed bench for gap_sync_ctrl on a 60-2 wheel: tooth period 100, gap 300,
// min 10, max 2000; per-edge expectations go through a scoreboard queue.
module tb_gap_sync_ctrl;
  import hwag_pkg::*;

  localparam int W     = 16;
  localparam int TEETH = 58;

`ifdef GAP_SYNC_ERR_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, cap_strobe, err_clr;
  logic [W-1:0] min_v, max_v;
  logic [5:0]   tooth_num;
  logic         sync, gap_pulse, err_pulse, stall;
  logic [7:0]   err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [5:0] tn;
    logic       sy;
    logic       gp;
    logic       ep;
    logic       st;
  } exp_t;

  exp_t sb[$];

  gap_sync_ctrl #(.WIDTH(W), .TOOTH_NUM(TEETH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_strobe (cap_strobe),
    .min        (min_v),
    .max        (max_v),
    .err_clr    (err_clr),
    .tooth_num  (tooth_num),
    .sync       (sync),
    .gap_pulse  (gap_pulse),
    .err_pulse  (err_pulse),
    .stall      (stall),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int wheel_period(input int pos);
    return (pos == 0) ? 300 : 100;
  endfunction

  // Entered one cycle after the previous strobe edge (+1 ns); the strobe is
  // sampled when the period counter reads `period`, outputs checked one edge later.
  task automatic tooth(input int period, input int tn, input logic sy, input logic gp,
                       input logic ep, input logic st, input string tag);
    exp_t e, got;
    e = '{tn: 6'(tn), sy: sy, gp: gp, ep: ep, st: st};
    sb.push_back(e);
    repeat (period - 2) @(posedge clk);
    #1 cap_strobe = 1'b1;
    @(posedge clk);
    #1 cap_strobe = 1'b0;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check($sformatf("%s tooth_num", tag), 16'(tooth_num), 16'(got.tn));
    check($sformatf("%s sync", tag),      16'(sync),      16'(got.sy));
    check($sformatf("%s gap_pulse", tag), 16'(gap_pulse), 16'(got.gp));
    check($sformatf("%s err_pulse", tag), 16'(err_pulse), 16'(got.ep));
    check($sformatf("%s stall", tag),     16'(stall),     16'(got.st));
  endtask

  task automatic run_locked(input int start, input int stop, input string tag);
    int pos = start;
    while (1) begin
      tooth(wheel_period(pos), pos, 1'b1, pos == 1, 1'b0, 1'b0,
            $sformatf("%s[%0d]", tag, pos));
      if (pos == stop) break;
      pos = (pos + 1) % TEETH;
    end
  endtask

  task automatic run_unlocked(input int start, input int stop, input string tag);
    int pos = start;
    while (1) begin
      tooth(wheel_period(pos), 0, 1'b0, 1'b0, 1'b0, 1'b0,
            $sformatf("%s[%0d]", tag, pos));
      if (pos == stop) break;
      pos = (pos + 1) % TEETH;
    end
  endtask

  initial begin
    rst        = 1'b1;
    cap_strobe = 1'b0;
    err_clr    = 1'b0;
    min_v      = 16'd10;
    max_v      = 16'd2000;
    #12;
    check("reset tooth_num", 16'(tooth_num), 16'd0);
    check("reset sync",      16'(sync),      16'd0);
    check("reset gap_pulse", 16'(gap_pulse), 16'd0);
    check("reset err_pulse", 16'(err_pulse), 16'd0);
    check("reset stall",     16'(stall),     16'd0);
    check("reset err_cnt",   16'(err_cnt),   16'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Acquisition: first edge ignored, three fill edges, then search to the gap.
    run_unlocked(50, 0, "acq");
    tooth(100, 1, 1'b1, 1'b1, 1'b0, 1'b0, "acq_lock");

    // Two full locked revolutions: ...56,57,0,1 with one gap_pulse each.
    run_locked(2, 1, "rev_a");
    run_locked(2, 1, "rev_b");

    // Gap replaced by a normal tooth: 0 is accepted, the 0->1 check fails.
    run_locked(2, 57, "pre_miss");
    tooth(100, 0, 1'b1, 1'b0, 1'b0, 1'b0, "miss_0");
    tooth(100, 0, 1'b0, 1'b0, 1'b1, 1'b0, "miss_err");
    check("miss state", 16'(dut.state), 16'(ST_FILL));
    run_unlocked(2, 0, "miss_reacq");
    tooth(100, 1, 1'b1, 1'b1, 1'b0, 1'b0, "miss_lock");

    // Extra strobe 5 clocks after an edge is noise and drops sync.
    run_locked(2, 10, "pre_extra");
    tooth(5, 0, 1'b0, 1'b0, 1'b1, 1'b0, "extra_err");
    tooth(95, 0, 1'b0, 1'b0, 1'b0, 1'b0, "extra_11");
    run_unlocked(12, 0, "extra_reacq");
    tooth(100, 1, 1'b1, 1'b1, 1'b0, 1'b0, "extra_lock");

    // Third sync loss, then the loss counter and its clear.
    run_locked(2, 20, "pre_third");
    tooth(5, 0, 1'b0, 1'b0, 1'b1, 1'b0, "third_err");
    tooth(95, 0, 1'b0, 1'b0, 1'b0, 1'b0, "third_21");
    check("err_cnt after 3 losses", 16'(err_cnt), 16'(CNT_EN * 3));
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("err_cnt after clear", 16'(err_cnt), 16'd0);
    run_unlocked(22, 0, "third_reacq");
    tooth(100, 1, 1'b1, 1'b1, 1'b0, 1'b0, "third_lock");

    // Stall: exactly 2000 clocks after the last edge.
    run_locked(2, 5, "pre_stall");
    repeat (1998) @(posedge clk);
    #1;
    check("stall at 1999", 16'(stall), 16'd0);
    check("sync at 1999",  16'(sync),  16'd1);
    @(posedge clk);
    #1;
    check("stall at 2000",     16'(stall),     16'd1);
    check("sync at 2000",      16'(sync),      16'd0);
    check("tooth_num at 2000", 16'(tooth_num), 16'd0);
    tooth(100, 0, 1'b0, 1'b0, 1'b0, 1'b0, "stall_clear");
    run_unlocked(31, 0, "stall_reacq");
    tooth(100, 1, 1'b1, 1'b1, 1'b0, 1'b0, "stall_lock");

    // Asynchronous reset mid-revolution, then a full re-acquisition.
    run_locked(2, 20, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("midrst tooth_num", 16'(tooth_num), 16'd0);
    check("midrst sync",      16'(sync),      16'd0);
    check("midrst gap_pulse", 16'(gap_pulse), 16'd0);
    check("midrst err_pulse", 16'(err_pulse), 16'd0);
    check("midrst stall",     16'(stall),     16'd0);
    check("midrst err_cnt",   16'(err_cnt),   16'd0);
    #1 rst = 1'b0;
    run_unlocked(21, 0, "rst_reacq");
    tooth(100, 1, 1'b1, 1'b1, 1'b0, 1'b0, "rst_lock");
    run_locked(2, 4, "post_rst");
    check("final err_cnt", 16'(err_cnt), 16'd0);
    check("scoreboard empty", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
